// File: rtl/i2s_rx.sv
// I2S receiver for a PCM1808 ADC: makes SCKI/BCK/LRCK from a free-running counter and captures a left/right sample pair per frame.
// Latency: valid pulses when the counter reads 8*DW+5+256, one clk after the last right data bit. No backpressure: valid is a lost-if-ignored pulse.
// Optional I2S_RX_ROUND16_EN adds left16/right16, which are rounded and saturated 16-bit copies of the samples.
module i2s_rx #(
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          din,
    output logic          scki,
    output logic          bck,
    output logic          lrck,
    output logic [DW-1:0] left,
    output logic [DW-1:0] right,
`ifdef I2S_RX_ROUND16_EN
    output logic [15:0]   left16,
    output logic [15:0]   right16,
`endif
    output logic          valid
);

    localparam logic [8:0] L_DONE    = 9'(8 * DW + 4);
    localparam logic [8:0] R_DONE    = 9'(256 + 8 * DW + 4);
    localparam logic [4:0] LAST_SLOT = 5'(DW);

    logic [8:0]    cnt;
    logic [DW-2:0] left_sh;
    logic [DW-2:0] right_sh;
    logic [DW-1:0] left_hold;
    logic [DW-1:0] left_next;
    logic [DW-1:0] right_next;
    logic [4:0]    slot;
    logic          sample_en;

    assign scki = cnt[0];
    assign bck  = cnt[2];
    assign lrck = cnt[8];

    // Slot 0 carries the one-bit I2S delay; only slots 1..DW hold data.
    assign slot      = cnt[7:3];
    assign sample_en = (cnt[2:0] == 3'b100) && (slot != 5'd0) && (slot <= LAST_SLOT);

    // The final data bit arrives on the same edge that transfers the word, so include it here.
    assign left_next  = {left_sh, din};
    assign right_next = {right_sh, din};

`ifdef I2S_RX_ROUND16_EN
    logic [15:0] left16_next;
    logic [15:0] right16_next;

    generate
        if (DW == 16) begin : g_pass
            assign left16_next  = left_hold;
            assign right16_next = right_next;
        end else begin : g_round
            logic [15:0] lsum;
            logic [15:0] rsum;
            assign lsum = left_hold[DW-1:DW-16] + 16'(left_hold[DW-17]);
            assign rsum = right_next[DW-1:DW-16] + 16'(right_next[DW-17]);
            // Only a positive value can wrap when rounding up.
            assign left16_next  = (!left_hold[DW-1] && lsum[15]) ? 16'h7FFF : lsum;
            assign right16_next = (!right_next[DW-1] && rsum[15]) ? 16'h7FFF : rsum;
        end
    endgenerate
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            left_sh   <= '0;
            right_sh  <= '0;
            left_hold <= '0;
            left      <= '0;
            right     <= '0;
            valid     <= 1'b0;
`ifdef I2S_RX_ROUND16_EN
            left16    <= '0;
            right16   <= '0;
`endif
        end else begin
            cnt   <= cnt + 9'd1;
            valid <= 1'b0;
            if (sample_en) begin
                if (cnt[8]) right_sh <= right_next[DW-2:0];
                else        left_sh  <= left_next[DW-2:0];
            end
            if (cnt == L_DONE) left_hold <= left_next;
            if (cnt == R_DONE) begin
                left  <= left_hold;
                right <= right_next;
                valid <= 1'b1;
`ifdef I2S_RX_ROUND16_EN
                left16  <= left16_next;
                right16 <= right16_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: a PCM1808-style source with random and directed frames, checked against a frame-level model.
// Checks clock outputs, valid timing, the samples, and (when the macro is defined) the rounded 16-bit outputs every cycle.
module tb_i2s_rx;

    localparam int DW = 24;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        fill;
    } frame_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          din;
    logic          scki, bck, lrck, valid;
    logic [DW-1:0] left, right;
`ifdef I2S_RX_ROUND16_EN
    logic [15:0]   left16, right16;
    logic [15:0]   exp_l16, exp_r16;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0]  ph;
    logic [23:0] fl, fr, exp_l, exp_r;
    logic        filler, exp_v;
    frame_t      fq[$];

    i2s_rx #(.DW(DW)) dut (
        .clk    (clk),
        .reset  (reset),
        .din    (din),
        .scki   (scki),
        .bck    (bck),
        .lrck   (lrck),
        .left   (left),
        .right  (right),
`ifdef I2S_RX_ROUND16_EN
        .left16 (left16),
        .right16(right16),
`endif
        .valid  (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (ph=%0d)", tag, obs, exp, ph);
        end
    endtask

    // Round half up to 16 bits, saturating at +32767.
    function automatic logic [15:0] rnd16(input logic [23:0] x);
        int xs;
        int q;
        xs = int'($signed(x));
        q  = (xs + 128) >>> 8;
        if (q > 32767) q = 32767;
        return q[15:0];
    endfunction

    task automatic pick_frame();
        frame_t f;
        if (fq.size() > 0) begin
            f = fq.pop_front();
        end else begin
            f.l    = 24'($urandom);
            f.r    = 24'($urandom);
            f.fill = 1'($urandom);
        end
        fl = f.l;
        fr = f.r;
        filler = f.fill;
    endtask

    // One clk: advance the model phase, drive the next serial bit, and compare every output.
    task automatic step();
        logic        r;
        int          slot;
        logic [23:0] s;
        r = reset;
        @(posedge clk);
        ph = r ? 9'd0 : ph + 9'd1;
        #1;
        if (r) begin
            exp_l = '0;
            exp_r = '0;
            exp_v = 1'b0;
`ifdef I2S_RX_ROUND16_EN
            exp_l16 = '0;
            exp_r16 = '0;
`endif
        end else begin
            exp_v = (ph == 9'd453);
            if (exp_v) begin
                exp_l = fl;
                exp_r = fr;
`ifdef I2S_RX_ROUND16_EN
                exp_l16 = rnd16(fl);
                exp_r16 = rnd16(fr);
`endif
            end
        end
        if (!r && ph == 9'd1) pick_frame();
        slot = (int'(ph) % 256) / 8;
        s    = (ph >= 9'd256) ? fr : fl;
        if (slot >= 1 && slot <= DW) din = s[DW - slot];
        else                         din = filler;

        chk("scki",  32'(scki),  32'(ph[0]));
        chk("bck",   32'(bck),   32'(ph[2]));
        chk("lrck",  32'(lrck),  32'(ph[8]));
        chk("valid", 32'(valid), 32'(exp_v));
        chk("left",  32'(left),  32'(exp_l));
        chk("right", 32'(right), 32'(exp_r));
`ifdef I2S_RX_ROUND16_EN
        chk("left16",  32'(left16),  32'(exp_l16));
        chk("right16", 32'(right16), 32'(exp_r16));
`endif
    endtask

    initial begin
        frame_t f;
        int     guard;
        reset  = 1'b1;
        din    = 1'b0;
        ph     = '0;
        fl     = '0;
        fr     = '0;
        filler = 1'b0;
        exp_l  = '0;
        exp_r  = '0;
        exp_v  = 1'b0;
`ifdef I2S_RX_ROUND16_EN
        exp_l16 = '0;
        exp_r16 = '0;
`endif
        // Reset state: every output low.
        repeat (5) step();

        f.l = 24'h123456; f.r = 24'hABCDEF; f.fill = 1'b0; fq.push_back(f);
        // Filler bits high, data zero: nothing outside slots 1..DW may leak in.
        f.l = 24'h000000; f.r = 24'h000000; f.fill = 1'b1; fq.push_back(f);
        for (int i = 1; i <= 4; i++) begin
            f.l = 24'(i); f.r = 24'($urandom); f.fill = 1'($urandom); fq.push_back(f);
        end
`ifdef I2S_RX_ROUND16_EN
        f.l = 24'h123480; f.r = 24'h800000; f.fill = 1'b0; fq.push_back(f);
        f.l = 24'h12347F; f.r = 24'hFFFF7F; f.fill = 1'b1; fq.push_back(f);
        f.l = 24'h7FFF80; f.r = 24'h7FFF7F; f.fill = 1'b0; fq.push_back(f);
`endif
        reset = 1'b0;
        repeat ((fq.size() + 2) * 512) step();

        // Reset in the middle of the right half: partial data must be discarded.
        guard = 0;
        while (ph != 9'd300 && guard < 600) begin
            step();
            guard++;
        end
        chk("reach_ph300", 32'(guard < 600), 32'd1);
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (3 * 512) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
